sys_bus_hs: RTL and testbench
=============================

SYS_BUS_HS -- requirements
Module: sys_bus_hs

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter NUM_SLAVES, default 4, SHALL set the slave port count (1..16).
REQ-003 Parameter DATA_W, default 32, SHALL set the data width (multiple of 8).
REQ-004 Parameters SEL_MSB and SEL_LSB, defaults 31 and 28, SHALL set the address field used as the slave index.
REQ-005 Parameter TIMEOUT_CYC, default 255, SHALL set the maximum number of wait cycles per access (>=1).
REQ-006 Parameter ERR_RDATA, default 32'hDEAD_BEEF, SHALL set the read data returned on error.
REQ-007 The ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- m_req  in  1  master request, held until m_ready
- m_addr  in  32  master address
- m_wdata  in  DATA_W  master write data
- m_wmask  in  DATA_W/8  byte write mask
- m_wen  in  1  1=write, 0=read
- m_rdata  out  DATA_W  registered read data
- m_ready  out  1  one-cycle completion pulse
- m_err  out  1  error flag, valid with m_ready
- s_req  out  NUM_SLAVES  one-hot slave request
- s_addr  out  32  latched address, broadcast
- s_wdata  out  DATA_W  latched write data, broadcast
- s_wmask  out  DATA_W/8  latched mask, gated to 0 on reads
- s_wen  out  1  latched write enable
- s_rdata  in  NUM_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
- s_ready  in  NUM_SLAVES  per-slave completion
- err_count  out  16  saturating error counter

Function
REQ-008 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-009 In IDLE with m_req=1, the block SHALL latch m_addr, m_wdata, m_wmask and m_wen, and decode sel=m_addr[SEL_MSB:SEL_LSB].
REQ-010 If sel<NUM_SLAVES, the next state SHALL be ACCESS; s_req[sel] SHALL be 1 from the next cycle, with all other s_req bits 0.
REQ-011 If sel>=NUM_SLAVES, the next state SHALL be RESP with err=1 and rdata=ERR_RDATA; no s_req bit SHALL assert.
REQ-012 In ACCESS, s_req[sel] SHALL stay high, and the wait counter (reset to 0 on ACCESS entry) SHALL increment each cycle while s_ready[sel]=0.
REQ-013 In ACCESS with s_ready[sel]=1, the block SHALL go to RESP with err=0, and capture s_rdata[sel] into m_rdata on reads; m_rdata SHALL be unchanged on writes.
REQ-014 In ACCESS when the wait counter equals TIMEOUT_CYC and s_ready[sel]=0, the block SHALL go to RESP with err=1; on reads rdata SHALL be ERR_RDATA.
REQ-015 If s_ready[sel] and timeout coincide, s_ready SHALL win (err=0).
REQ-016 s_ready bits of unselected slaves SHALL be ignored.
REQ-017 In RESP, m_ready SHALL be 1 for exactly one cycle and m_err SHALL equal the recorded err; the next state SHALL be IDLE.
REQ-018 m_req SHALL be sampled only in IDLE, so a held m_req starts a new access the cycle after RESP.
REQ-019 Minimum latency SHALL be: m_req sampled at edge N, s_req high after N, s_ready seen at N+1, m_ready high after N+1.
REQ-020 m_rdata SHALL hold its value until the next captured read or error.
REQ-021 err_count SHALL increment by 1 on each RESP with err=1 and saturate at 16'hFFFF.
REQ-022 When not compiled for synthesis, the block SHALL print a message on a decode error or timeout.

Reset
REQ-023 On rst_n=0 the block SHALL immediately set state=IDLE, and clear s_req, m_ready, m_err, m_rdata, err_count, the wait counter and all latched request fields to 0.
REQ-024 A reset during ACCESS SHALL drop s_req asynchronously and produce no m_ready pulse.
REQ-025 After rst_n deasserts, the first m_req SHALL be sampled on the first rising clk edge.

Verification
REQ-026 Read 0x1000_0004, with slave 1 giving s_ready=1 and s_rdata=0x1234_5678 one cycle after s_req -> m_ready pulses after 2 edges, m_rdata=0x1234_5678, m_err=0.
REQ-027 Write 0x2000_0000, data 0xA5A5_A5A5, mask 4'b0011, slave 2 ready after 5 cycles -> s_wmask=0011 and s_wdata stable throughout; m_ready one cycle; m_rdata unchanged.
REQ-028 Read 0x5000_0000 with NUM_SLAVES=4 -> no s_req, m_ready after 1 edge, m_err=1, m_rdata=0xDEAD_BEEF, err_count=1.
REQ-029 With TIMEOUT_CYC=8 and slave 3 never ready -> s_req[3] high for 9 cycles, then m_err=1 and s_req cleared; ready arriving on the timeout cycle -> m_err=0.
REQ-030 With m_req held across two accesses -> exactly one IDLE cycle between accesses; rst_n pulsed mid-ACCESS -> s_req=0 immediately, no m_ready, err_count=0.

Source files
------------

// File: rtl/sys_bus_hs.sv
// sys_bus_hs: single-master to NUM_SLAVES request/ready bus bridge.
// The master request is latched in IDLE, routed as a one-hot s_req,
// bounded by a wait-cycle timeout, and answered with a one-cycle
// m_ready pulse that carries the error flag.
module sys_bus_hs #(
    parameter int unsigned       NUM_SLAVES  = 4,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       SEL_MSB     = 31,
    parameter int unsigned       SEL_LSB     = 28,
    parameter int unsigned       TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA   = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m_req,
    input  logic [31:0]                  m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wmask,
    input  logic                         m_wen,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_req,
    output logic [31:0]                  s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wmask,
    output logic                         s_wen,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    output logic [15:0]                  err_count
);

    localparam int unsigned SEL_W  = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned CNT_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t             state, state_nxt;

    logic [SEL_W-1:0]   sel_q;
    logic [31:0]        addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [MASK_W-1:0]  wmask_q;
    logic               wen_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               err_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [15:0]        err_cnt_q;

    logic [SEL_W-1:0]   sel_d;
    logic               sel_valid;
    logic               sel_ready;
    logic [DATA_W-1:0]  sel_rdata;
    logic               timeout;
    logic               enter_resp;
    logic               nxt_err;
    logic               load_rdata;
    logic [DATA_W-1:0]  nxt_rdata;

    assign sel_d     = m_addr[SEL_MSB:SEL_LSB];
    assign sel_valid = 32'(sel_d) < NUM_SLAVES;
    assign timeout   = (wait_cnt == CNT_W'(TIMEOUT_CYC));

    assign m_ready   = (state == RESP);
    assign m_err     = (state == RESP) && err_q;
    assign m_rdata   = rdata_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_wmask   = wen_q ? wmask_q : '0;
    assign s_wen     = wen_q;
    assign err_count = err_cnt_q;

    // Select the addressed slave's ready/rdata; drive its request only in ACCESS
    // so an asynchronous reset of the state drops s_req at once.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        s_req     = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (32'(sel_q) == i) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
                s_req[i]  = (state == ACCESS);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and response decisions; ready wins over a coincident timeout.
    always_comb begin
        state_nxt  = state;
        enter_resp = 1'b0;
        nxt_err    = 1'b0;
        load_rdata = 1'b0;
        nxt_rdata  = rdata_q;
        unique case (state)
            IDLE: begin
                if (m_req) begin
                    if (sel_valid) begin
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                        nxt_err    = 1'b1;
                        load_rdata = 1'b1;
                        nxt_rdata  = ERR_RDATA;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                    if (!wen_q) begin
                        load_rdata = 1'b1;
                        nxt_rdata  = sel_rdata;
                    end
                end else if (timeout) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                    nxt_err    = 1'b1;
                    if (!wen_q) begin
                        load_rdata = 1'b1;
                        nxt_rdata  = ERR_RDATA;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latches, wait counter, response data/flag and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            wen_q     <= 1'b0;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            if (state == IDLE && m_req) begin
                sel_q   <= sel_d;
                addr_q  <= m_addr;
                wdata_q <= m_wdata;
                wmask_q <= m_wmask;
                wen_q   <= m_wen;
            end
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if (state == ACCESS && !sel_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (enter_resp) begin
                err_q <= nxt_err;
            end
            if (load_rdata) begin
                rdata_q <= nxt_rdata;
            end
            if (enter_resp && nxt_err && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

`ifndef SYNTHESIS
    // Simulation-only notice of decode misses and slave timeouts.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && nxt_err) begin
            if (state == IDLE) begin
                $display("sys_bus_hs: decode miss, addr=%h", m_addr);
            end else begin
                $display("sys_bus_hs: slave timeout, addr=%h", addr_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sys_bus_hs.sv
// tb_sys_bus_hs: directed and randomized accesses against a transaction-level
// expectation (latency, error, read data, error count) derived from the
// slave delay chosen for each access.
module tb_sys_bus_hs;

    localparam int          NS   = 4;
    localparam int          DW   = 32;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             m_req;
    logic [31:0]      m_addr;
    logic [DW-1:0]    m_wdata;
    logic [DW/8-1:0]  m_wmask;
    logic             m_wen;
    logic [DW-1:0]    m_rdata;
    logic             m_ready;
    logic             m_err;
    logic [NS-1:0]    s_req;
    logic [31:0]      s_addr;
    logic [DW-1:0]    s_wdata;
    logic [DW/8-1:0]  s_wmask;
    logic             s_wen;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0]    s_ready;
    logic [15:0]      err_count;

    always #5 clk = ~clk;

    sys_bus_hs #(
        .NUM_SLAVES (NS),
        .DATA_W     (DW),
        .SEL_MSB    (31),
        .SEL_LSB    (28),
        .TIMEOUT_CYC(TO),
        .ERR_RDATA  (ERRD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wmask  (m_wmask),
        .m_wen    (m_wen),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .s_req    (s_req),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wmask  (s_wmask),
        .s_wen    (s_wen),
        .s_rdata  (s_rdata),
        .s_ready  (s_ready),
        .err_count(err_count)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_rdata;
    int          exp_errcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One master access. dly = cycles of s_req before the slave raises ready
    // (0 = ready in the first s_req cycle); dly > TO means the slave never answers.
    // from_resp = m_req is raised while the previous access is in its response cycle.
    task automatic do_access(input logic [31:0] addr, input logic wen, input logic [31:0] wd,
                             input logic [3:0] wm, input int dly, input logic [31:0] sdata,
                             input bit from_resp);
        int          sel;
        bit          dec_err;
        bit          to_err;
        int          exp_edges;
        int          exp_reqc;
        logic [3:0]  exp_sreq;
        logic [31:0] prev_rdata;
        int          edges;
        int          reqc;
        bit          done;
        sel       = int'(addr[31:28]);
        dec_err   = (sel >= NS);
        to_err    = !dec_err && (dly > TO);
        exp_edges = dec_err ? 1 : (to_err ? TO + 2 : dly + 2);
        exp_reqc  = dec_err ? 0 : (to_err ? TO + 1 : dly + 1);
        if (from_resp) exp_edges++;
        exp_sreq  = '0;
        if (!dec_err) exp_sreq[sel] = 1'b1;
        prev_rdata = exp_rdata;
        if (dec_err || (to_err && !wen)) exp_rdata = ERRD;
        else if (!to_err && !wen)        exp_rdata = sdata;
        if (dec_err || to_err) exp_errcnt = (exp_errcnt == 65535) ? 65535 : exp_errcnt + 1;

        m_req   = 1'b1;
        m_addr  = addr;
        m_wen   = wen;
        m_wdata = wd;
        m_wmask = wm;
        for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = (i == sel) ? sdata : $urandom;
        s_ready = '0;
        edges = 0;
        reqc  = 0;
        done  = 1'b0;
        while (!done && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (m_ready) begin
                done = 1'b1;
                chk("latency",      64'(edges),      64'(exp_edges));
                chk("m_err",        64'(m_err),      64'(dec_err || to_err));
                chk("m_rdata",      64'(m_rdata),    64'(exp_rdata));
                chk("err_count",    64'(err_count),  64'(exp_errcnt));
                chk("s_req_cycles", 64'(reqc),       64'(exp_reqc));
                chk("s_req_resp",   64'(s_req),      64'(0));
                m_req = 1'b0;
            end else if (s_req != '0) begin
                reqc++;
                chk("s_req_onehot", 64'(s_req),   64'(exp_sreq));
                chk("s_addr",       64'(s_addr),  64'(addr));
                chk("s_wdata",      64'(s_wdata), 64'(wd));
                chk("s_wmask",      64'(s_wmask), 64'(wen ? wm : 4'h0));
                chk("s_wen",        64'(s_wen),   64'(wen));
                chk("m_rdata_hold", 64'(m_rdata), 64'(prev_rdata));
                s_ready = 4'($urandom) & ~exp_sreq;
                if (reqc - 1 == dly) s_ready = s_ready | exp_sreq;
                m_addr  = $urandom;
                m_wdata = $urandom;
                m_wmask = 4'($urandom);
                m_wen   = 1'($urandom);
                for (int i = 0; i < NS; i++) if (i != sel) s_rdata[i*DW +: DW] = $urandom;
            end else begin
                s_ready = 4'($urandom);
            end
        end
        chk("m_ready_seen", 64'(done), 64'(1));
        s_ready = '0;
    endtask

    task automatic idle_cycle();
        m_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("m_ready_pulse", 64'(m_ready), 64'(0));
        chk("s_req_idle",    64'(s_req),   64'(0));
    endtask

    initial begin
        bit          hold;
        bit          prev_hold;
        logic [31:0] a;
        rst_n   = 1'b0;
        m_req   = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wmask = '0;
        m_wen   = 1'b0;
        s_rdata = '0;
        s_ready = '0;
        exp_rdata  = '0;
        exp_errcnt = 0;

        repeat (2) @(negedge clk);
        chk("rst_m_ready",   64'(m_ready),   64'(0));
        chk("rst_m_err",     64'(m_err),     64'(0));
        chk("rst_m_rdata",   64'(m_rdata),   64'(0));
        chk("rst_err_count", 64'(err_count), 64'(0));
        chk("rst_s_req",     64'(s_req),     64'(0));
        chk("rst_s_addr",    64'(s_addr),    64'(0));
        chk("rst_s_wdata",   64'(s_wdata),   64'(0));
        chk("rst_s_wen",     64'(s_wen),     64'(0));
        rst_n = 1'b1;

        // Read hitting slave 1 on the first edge after reset release.
        do_access(32'h1000_0004, 1'b0, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0);
        idle_cycle();
        // Write to slave 2, ready after 5 wait cycles.
        do_access(32'h2000_0000, 1'b1, 32'hA5A5_A5A5, 4'b0011, 5, $urandom, 1'b0);
        idle_cycle();
        // Decode miss.
        do_access(32'h5000_0000, 1'b0, 32'h0, 4'h0, 0, $urandom, 1'b0);
        idle_cycle();
        // Read timeout on slave 3.
        do_access(32'h3000_0010, 1'b0, 32'h0, 4'h0, 99, $urandom, 1'b0);
        idle_cycle();
        // Ready on the timeout cycle itself.
        do_access(32'h3000_0020, 1'b0, 32'h0, 4'h0, TO, 32'hCAFE_F00D, 1'b0);
        idle_cycle();
        // Write timeout leaves m_rdata alone.
        do_access(32'h3000_0030, 1'b1, 32'h1111_2222, 4'b1100, 99, $urandom, 1'b0);
        idle_cycle();
        // Held m_req across two accesses.
        do_access(32'h0000_0100, 1'b0, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b0);
        do_access(32'h1000_0200, 1'b1, 32'h7777_8888, 4'b1010, 2, $urandom, 1'b1);
        idle_cycle();

        prev_hold = 1'b0;
        for (int n = 0; n < 40; n++) begin
            a    = {4'($urandom_range(0, 5)), 28'($urandom)};
            hold = 1'($urandom) && (n != 39);
            do_access(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 10)),
                      $urandom, prev_hold);
            if (!hold) idle_cycle();
            prev_hold = hold;
        end

        // Reset in the middle of an access to slave 3.
        m_req   = 1'b1;
        m_addr  = 32'h3000_0000;
        m_wen   = 1'b0;
        s_ready = '0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_s_req", 64'(s_req), 64'(4'b1000));
        m_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_s_req",     64'(s_req),     64'(0));
        chk("async_rst_m_ready",   64'(m_ready),   64'(0));
        chk("async_rst_err_count", 64'(err_count), 64'(0));
        chk("async_rst_m_rdata",   64'(m_rdata),   64'(0));
        exp_rdata  = '0;
        exp_errcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("no_ready_after_rst", 64'(m_ready), 64'(0));
        end
        do_access(32'h5000_0000, 1'b1, 32'h0, 4'h0, 0, $urandom, 1'b0);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
